// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: resolves load-use, jump, branch and multi-cycle memory
// hazards into PC / pipeline-register controls, with a memory watchdog and stall counter.
module hazard_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  IF_ID_RsAddr,
    input  logic [4:0]  IF_ID_RtAddr,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  ID_EX_RtAddr,
    input  logic        BranchTaken,
    input  logic        JumpID,
    input  logic        MemReq,
    input  logic        MemDone,
    output logic        PCWrite,
    output logic        PCSrcBranch,
    output logic [1:0]  IF_ID_HzCtrl,
    output logic [1:0]  ID_EX_HzCtrl,
    output logic        MemStall,
    output logic        Timeout,
    output logic [15:0] StallCycles,
    output logic [1:0]  dbg_state
);

    // Valid/ready is not used here: every input is a same-cycle qualifier sampled on
    // the rising edge, and every control output is valid for the cycle it is driven.
    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_FLUSH    = 2'd2
    } state_t;

    localparam logic [1:0] HZ_NORMAL = 2'b00;
    localparam logic [1:0] HZ_FLUSH  = 2'b01;
    localparam logic [1:0] HZ_STALL  = 2'b10;

    state_t      state_q, state_d;
    logic        pend_flush_q, pend_flush_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        timeout_q, timeout_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;

    logic load_use;
    logic mem_release;

    // Register zero is hardwired, so a load targeting it never creates a dependency.
    assign load_use = ID_EX_MemRead && (ID_EX_RtAddr != 5'd0) &&
                      ((ID_EX_RtAddr == IF_ID_RsAddr) || (ID_EX_RtAddr == IF_ID_RtAddr));

    // The watchdog forces completion once the wait counter has reached its ceiling.
    assign mem_release = MemDone || (wait_cnt_q == 8'hFF);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_RUN;
            pend_flush_q   <= 1'b0;
            wait_cnt_q     <= 8'd0;
            timeout_q      <= 1'b0;
            stall_cycles_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            pend_flush_q   <= pend_flush_d;
            wait_cnt_q     <= wait_cnt_d;
            timeout_q      <= timeout_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        pend_flush_d = pend_flush_q;
        wait_cnt_d   = wait_cnt_q;
        timeout_d    = timeout_q;
        case (state_q)
            S_RUN: begin
                if (MemReq) begin
                    state_d      = S_MEM_WAIT;
                    wait_cnt_d   = 8'd0;
                    pend_flush_d = pend_flush_q | BranchTaken;
                end
            end
            S_MEM_WAIT: begin
                if (mem_release) begin
                    if (!MemDone) begin
                        timeout_d = 1'b1;
                    end
                    state_d = pend_flush_q ? S_FLUSH : S_RUN;
                end else begin
                    wait_cnt_d   = wait_cnt_q + 8'd1;
                    pend_flush_d = pend_flush_q | BranchTaken;
                end
            end
            S_FLUSH: begin
                pend_flush_d = 1'b0;
                state_d      = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    // Output logic
    always_comb begin
        PCWrite      = 1'b1;
        PCSrcBranch  = 1'b0;
        IF_ID_HzCtrl = HZ_NORMAL;
        ID_EX_HzCtrl = HZ_NORMAL;
        MemStall     = 1'b0;
        if (rst) begin
            PCWrite      = 1'b0;
            IF_ID_HzCtrl = HZ_FLUSH;
            ID_EX_HzCtrl = HZ_FLUSH;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (MemReq) begin
                        PCWrite      = 1'b0;
                        IF_ID_HzCtrl = HZ_STALL;
                        ID_EX_HzCtrl = HZ_STALL;
                        MemStall     = 1'b1;
                    end else if (BranchTaken) begin
                        PCSrcBranch  = 1'b1;
                        IF_ID_HzCtrl = HZ_FLUSH;
                        ID_EX_HzCtrl = HZ_FLUSH;
                    end else if (load_use) begin
                        PCWrite      = 1'b0;
                        IF_ID_HzCtrl = HZ_STALL;
                        ID_EX_HzCtrl = HZ_FLUSH;
                    end else if (JumpID) begin
                        IF_ID_HzCtrl = HZ_FLUSH;
                    end
                end
                S_MEM_WAIT: begin
                    if (!mem_release) begin
                        PCWrite      = 1'b0;
                        IF_ID_HzCtrl = HZ_STALL;
                        ID_EX_HzCtrl = HZ_STALL;
                        MemStall     = 1'b1;
                    end
                end
                S_FLUSH: begin
                    PCSrcBranch  = 1'b1;
                    IF_ID_HzCtrl = HZ_FLUSH;
                    ID_EX_HzCtrl = HZ_FLUSH;
                end
                default: begin
                    PCWrite = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!PCWrite && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    assign Timeout     = timeout_q;
    assign StallCycles = stall_cycles_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: one task per scenario, inline comparisons
// against hand-computed control vectors and a bench-tracked stall count.
module tb_hazard_sequencer;

    logic        clk;
    logic        rst;
    logic [4:0]  IF_ID_RsAddr;
    logic [4:0]  IF_ID_RtAddr;
    logic        ID_EX_MemRead;
    logic [4:0]  ID_EX_RtAddr;
    logic        BranchTaken;
    logic        JumpID;
    logic        MemReq;
    logic        MemDone;
    logic        PCWrite;
    logic        PCSrcBranch;
    logic [1:0]  IF_ID_HzCtrl;
    logic [1:0]  ID_EX_HzCtrl;
    logic        MemStall;
    logic        Timeout;
    logic [15:0] StallCycles;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_stall = 16'd0;

    // {PCWrite, PCSrcBranch, IF_ID_HzCtrl, ID_EX_HzCtrl, MemStall}
    logic [6:0] outs;
    assign outs = {PCWrite, PCSrcBranch, IF_ID_HzCtrl, ID_EX_HzCtrl, MemStall};

    localparam logic [6:0] O_NORM  = 7'b1_0_00_00_0;
    localparam logic [6:0] O_FULL  = 7'b0_0_10_10_1;
    localparam logic [6:0] O_FLUSH = 7'b1_1_01_01_0;
    localparam logic [6:0] O_LU    = 7'b0_0_10_01_0;
    localparam logic [6:0] O_JMP   = 7'b1_0_01_00_0;
    localparam logic [6:0] O_RST   = 7'b0_0_01_01_0;

    hazard_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .IF_ID_RsAddr  (IF_ID_RsAddr),
        .IF_ID_RtAddr  (IF_ID_RtAddr),
        .ID_EX_MemRead (ID_EX_MemRead),
        .ID_EX_RtAddr  (ID_EX_RtAddr),
        .BranchTaken   (BranchTaken),
        .JumpID        (JumpID),
        .MemReq        (MemReq),
        .MemDone       (MemDone),
        .PCWrite       (PCWrite),
        .PCSrcBranch   (PCSrcBranch),
        .IF_ID_HzCtrl  (IF_ID_HzCtrl),
        .ID_EX_HzCtrl  (ID_EX_HzCtrl),
        .MemStall      (MemStall),
        .Timeout       (Timeout),
        .StallCycles   (StallCycles),
        .dbg_state     (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change 1 time unit after the rising edge, checks happen 2 later.
    task automatic drive(input logic mr, input logic [4:0] ex_rt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic bt, input logic jmp,
                         input logic mreq, input logic mdone);
        @(posedge clk);
        #1;
        ID_EX_MemRead = mr;
        ID_EX_RtAddr  = ex_rt;
        IF_ID_RsAddr  = rs;
        IF_ID_RtAddr  = rt;
        BranchTaken   = bt;
        JumpID        = jmp;
        MemReq        = mreq;
        MemDone       = mdone;
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (outs !== O_RST) begin n_fail++; $display("FAIL reset_outs: got %b want %b", outs, O_RST); end
        n_checks++;
        if (StallCycles !== 16'd0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", StallCycles); end
        n_checks++;
        if (Timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", Timeout); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_normal();
        idle();
        n_checks++;
        if (outs !== O_NORM) begin n_fail++; $display("FAIL normal_outs: got %b want %b", outs, O_NORM); end
        n_checks++;
        if (StallCycles !== exp_stall) begin n_fail++; $display("FAIL normal_stall: got %0d want %0d", StallCycles, exp_stall); end
    endtask

    task automatic test_load_use();
        drive(1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (outs !== O_LU) begin n_fail++; $display("FAIL lu_rs_outs: got %b want %b", outs, O_LU); end
        exp_stall++;
        idle();
        n_checks++;
        if (outs !== O_NORM) begin n_fail++; $display("FAIL lu_rs_after: got %b want %b", outs, O_NORM); end
        n_checks++;
        if (StallCycles !== exp_stall) begin n_fail++; $display("FAIL lu_rs_stall: got %0d want %0d", StallCycles, exp_stall); end
        drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (outs !== O_LU) begin n_fail++; $display("FAIL lu_rt_outs: got %b want %b", outs, O_LU); end
        exp_stall++;
        drive(1'b0, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (outs !== O_NORM) begin n_fail++; $display("FAIL lu_noload: got %b want %b", outs, O_NORM); end
        n_checks++;
        if (StallCycles !== exp_stall) begin n_fail++; $display("FAIL lu_rt_stall: got %0d want %0d", StallCycles, exp_stall); end
    endtask

    task automatic test_zero_reg();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (outs !== O_NORM) begin n_fail++; $display("FAIL zero_reg_outs: got %b want %b", outs, O_NORM); end
        idle();
        n_checks++;
        if (StallCycles !== exp_stall) begin n_fail++; $display("FAIL zero_reg_stall: got %0d want %0d", StallCycles, exp_stall); end
    endtask

    task automatic test_branch_jump();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (outs !== O_FLUSH) begin n_fail++; $display("FAIL branch_outs: got %b want %b", outs, O_FLUSH); end
        idle();
        n_checks++;
        if (outs !== O_NORM) begin n_fail++; $display("FAIL branch_after: got %b want %b", outs, O_NORM); end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (outs !== O_JMP) begin n_fail++; $display("FAIL jump_outs: got %b want %b", outs, O_JMP); end
        drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (outs !== O_FLUSH) begin n_fail++; $display("FAIL branch_over_lu: got %b want %b", outs, O_FLUSH); end
    endtask

    task automatic test_lu_jump();
        drive(1'b1, 5'd12, 5'd1, 5'd12, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (outs !== O_LU) begin n_fail++; $display("FAIL lu_jump_outs: got %b want %b", outs, O_LU); end
        exp_stall++;
        drive(1'b0, 5'd0, 5'd1, 5'd12, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (outs !== O_JMP) begin n_fail++; $display("FAIL lu_jump_replay: got %b want %b", outs, O_JMP); end
        n_checks++;
        if (StallCycles !== exp_stall) begin n_fail++; $display("FAIL lu_jump_stall: got %0d want %0d", StallCycles, exp_stall); end
    endtask

    task automatic test_mem_branch();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (outs !== O_FULL) begin n_fail++; $display("FAIL memb_req: got %b want %b", outs, O_FULL); end
        exp_stall++;
        for (int i = 0; i < 3; i++) begin
            idle();
            n_checks++;
            if (outs !== O_FULL) begin n_fail++; $display("FAIL memb_wait%0d: got %b want %b", i, outs, O_FULL); end
            exp_stall++;
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (outs !== O_NORM) begin n_fail++; $display("FAIL memb_release: got %b want %b", outs, O_NORM); end
        idle();
        n_checks++;
        if (outs !== O_FLUSH) begin n_fail++; $display("FAIL memb_flush: got %b want %b", outs, O_FLUSH); end
        idle();
        n_checks++;
        if (outs !== O_NORM) begin n_fail++; $display("FAIL memb_run: got %b want %b", outs, O_NORM); end
        n_checks++;
        if (StallCycles !== exp_stall) begin n_fail++; $display("FAIL memb_stall: got %0d want %0d", StallCycles, exp_stall); end
    endtask

    task automatic test_timeout();
        int bad;
        bad = 0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (outs !== O_FULL) begin n_fail++; $display("FAIL to_req: got %b want %b", outs, O_FULL); end
        exp_stall++;
        for (int i = 0; i < 255; i++) begin
            idle();
            if (outs !== O_FULL && bad < 3) begin
                bad++;
                $display("FAIL to_wait%0d: got %b want %b", i, outs, O_FULL);
            end
            exp_stall++;
        end
        n_checks++;
        if (bad != 0) n_fail++;
        idle();
        n_checks++;
        if (outs !== O_NORM) begin n_fail++; $display("FAIL to_release: got %b want %b", outs, O_NORM); end
        idle();
        n_checks++;
        if (Timeout !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b want 1", Timeout); end
        n_checks++;
        if (outs !== O_NORM) begin n_fail++; $display("FAIL to_run: got %b want %b", outs, O_NORM); end
        n_checks++;
        if (StallCycles !== exp_stall) begin n_fail++; $display("FAIL to_stall: got %0d want %0d", StallCycles, exp_stall); end
        repeat (3) idle();
        n_checks++;
        if (Timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", Timeout); end
    endtask

    task automatic test_reset_midwait();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle();
        idle();
        n_checks++;
        if (outs !== O_FULL) begin n_fail++; $display("FAIL rmw_wait: got %b want %b", outs, O_FULL); end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (outs !== O_RST) begin n_fail++; $display("FAIL rmw_rst_outs: got %b want %b", outs, O_RST); end
        n_checks++;
        if (StallCycles !== 16'd0) begin n_fail++; $display("FAIL rmw_rst_stall: got %0d want 0", StallCycles); end
        n_checks++;
        if (Timeout !== 1'b0) begin n_fail++; $display("FAIL rmw_rst_timeout: got %b want 0", Timeout); end
        @(negedge clk);
        rst = 1'b0;
        exp_stall = 16'd0;
        idle();
        n_checks++;
        if (outs !== O_NORM) begin n_fail++; $display("FAIL rmw_first: got %b want %b", outs, O_NORM); end
        idle();
        n_checks++;
        if (outs !== O_NORM) begin n_fail++; $display("FAIL rmw_noflush: got %b want %b", outs, O_NORM); end
        n_checks++;
        if (StallCycles !== 16'd0) begin n_fail++; $display("FAIL rmw_stall: got %0d want 0", StallCycles); end
    endtask

    initial begin
        rst           = 1'b1;
        IF_ID_RsAddr  = 5'd0;
        IF_ID_RtAddr  = 5'd0;
        ID_EX_MemRead = 1'b0;
        ID_EX_RtAddr  = 5'd0;
        BranchTaken   = 1'b0;
        JumpID        = 1'b0;
        MemReq        = 1'b0;
        MemDone       = 1'b0;
        test_reset();
        test_normal();
        test_load_use();
        test_zero_reg();
        test_branch_jump();
        test_lu_jump();
        test_mem_branch();
        test_timeout();
        test_reset_midwait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-003 SHALL have port IF_ID_RsAddr  input  5  Rs field of instruction in ID.
REQ-004 SHALL have port IF_ID_RtAddr  input  5  Rt field of instruction in ID.
REQ-005 SHALL have port ID_EX_MemRead  input  1  instruction in EX is a load.
REQ-006 SHALL have port ID_EX_RtAddr  input  5  load destination register in EX.
REQ-007 SHALL have port BranchTaken  input  1  branch resolved taken in EX this cycle.
REQ-008 SHALL have port JumpID  input  1  jump decoded in ID this cycle.
REQ-009 SHALL have port MemReq  input  1  multi-cycle data-memory access starts in MEM.
REQ-010 SHALL have port MemDone  input  1  data-memory access completes this cycle.
REQ-011 SHALL have port PCWrite  output  1  PC register load enable.
REQ-012 SHALL have port PCSrcBranch  output  1  PC loads branch target this cycle.
REQ-013 SHALL have port IF_ID_HzCtrl  output  2  00 normal, 01 flush, 10 stall.
REQ-014 SHALL have port ID_EX_HzCtrl  output  2  same encoding, for ID/EX register.
REQ-015 SHALL have port MemStall  output  1  hold EX/MEM and MEM/WB registers.
REQ-016 SHALL have port Timeout  output  1  sticky memory-watchdog flag.
REQ-017 SHALL have port StallCycles  output  16  count of cycles with PCWrite=0.

Function
REQ-018 SHALL implement registered states RUN, MEM_WAIT, FLUSH; control outputs combinational from state and inputs.
REQ-019 Decision priority within a cycle SHALL be: MEM_WAIT/MemReq > pending/BranchTaken flush > load-use > JumpID > normal.
REQ-020 RUN, normal: PCWrite=1, PCSrcBranch=0, both HzCtrl=00, MemStall=0.
REQ-021 RUN, MemReq=1: full stall (PCWrite=0, both HzCtrl=10, MemStall=1); next state MEM_WAIT; WaitCnt cleared.
REQ-022 RUN, MemReq=1 and BranchTaken=1 same cycle: stall as REQ-021 and set PendFlush=1.
REQ-023 MEM_WAIT, MemDone=0: full stall; WaitCnt+1; BranchTaken=1 sets PendFlush.
REQ-024 MEM_WAIT, MemDone=1: outputs as RUN normal (MemStall=0) that cycle; next state FLUSH if PendFlush else RUN.
REQ-025 MEM_WAIT, WaitCnt=255 and MemDone=0: set Timeout=1, treat cycle as MemDone=1 (REQ-024).
REQ-026 FLUSH: PCWrite=1, PCSrcBranch=1, both HzCtrl=01; clear PendFlush; next state RUN; lasts exactly one cycle.
REQ-027 RUN, BranchTaken=1 (no MemReq): same outputs as FLUSH that cycle; state stays RUN.
REQ-028 RUN, load-use (ID_EX_MemRead=1, ID_EX_RtAddr!=0, equals IF_ID_RsAddr or IF_ID_RtAddr): PCWrite=0, IF_ID_HzCtrl=10, ID_EX_HzCtrl=01; one cycle, no state change.
REQ-029 ID_EX_RtAddr=0 SHALL never cause a load-use stall.
REQ-030 RUN, JumpID=1, no higher event: PCWrite=1, IF_ID_HzCtrl=01, ID_EX_HzCtrl=00.
REQ-031 Load-use and JumpID same cycle: load-use response only; jump honoured when re-presented.
REQ-032 StallCycles SHALL increment on every clock edge with PCWrite=0, saturate at 16'hFFFF.
REQ-033 Timeout SHALL remain 1 until rst.
REQ-034 HzCtrl value 11 SHALL never be driven.

Reset
REQ-035 rst=1 SHALL immediately force state RUN, PendFlush=0, WaitCnt=0, Timeout=0, StallCycles=0.
REQ-036 While rst=1: PCWrite=0, PCSrcBranch=0, both HzCtrl=01, MemStall=0.
REQ-037 rst asserted mid-MEM_WAIT SHALL discard PendFlush; first cycle after release is RUN normal.

Verification
REQ-038 ID_EX_MemRead=1, ID_EX_RtAddr=5, IF_ID_RsAddr=5 -> one cycle PCWrite=0, IF_ID=10, ID_EX=01; StallCycles 0->1.
REQ-039 Same with ID_EX_RtAddr=0, IF_ID_RsAddr=0 -> normal outputs, no stall.
REQ-040 MemReq+BranchTaken same cycle, MemDone 3 cycles later -> 4 stall cycles (MemStall=1), release cycle normal, next cycle FLUSH (both 01, PCSrcBranch=1), then RUN.
REQ-041 MemReq, MemDone held 0 -> stall through WaitCnt=255, Timeout=1 on release cycle, RUN afterwards, Timeout stays 1.
REQ-042 Load-use and JumpID together -> stall only; next cycle (no hazard) JumpID -> IF_ID=01, PCWrite=1.
REQ-043 rst pulse during MEM_WAIT with PendFlush=1 -> outputs per REQ-036 during rst; after release normal RUN, no FLUSH cycle, StallCycles=0.
